// File: rtl/jt89_wrseq.sv
// SN76489 write sequencer: FIFO-buffered register requests serialised into latch/data bytes on cen.
// First byte one cen after pop; req_ready = FIFO not full. JT89_WRSEQ_SHADOW_EN enables redundant-write suppression.
module jt89_wrseq #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_reg,
  input  logic [9:0] req_val,
  output logic       wr_n,
  output logic [7:0] dout,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] GAP_W = 4'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DATA, S_GAP} state_t;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, nonempty;

  state_t     st, st_n;
  logic       wr_n_n, pend, pend_n;
  logic [7:0] dout_n;
  logic [5:0] data_q, data_n;
  logic [3:0] gcnt, gcnt_n;

  logic [2:0] head_reg;
  logic [9:0] head_val;
  logic       is_tone, is_noise, drop, need_data;
  logic [3:0] low4;

  assign req_ready = count != (AW+1)'(DEPTH);
  assign push      = req_valid & req_ready;
  assign nonempty  = count != '0;
  assign busy      = nonempty || (st != S_IDLE);
  assign head_reg  = mem[rptr][12:10];
  assign head_val  = mem[rptr][9:0];
  assign is_noise  = head_reg == 3'b110;
  assign is_tone   = !head_reg[0] && !is_noise;
  assign low4      = is_noise ? {1'b0, head_val[2:0]} : head_val[3:0];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_reg, req_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

`ifdef JT89_WRSEQ_SHADOW_EN
  logic [9:0] shadow [8];
  logic [9:0] mask;

  assign mask      = is_tone ? 10'h3FF : (is_noise ? 10'h007 : 10'h00F);
  assign drop      = (head_val & mask) == shadow[head_reg];
  assign need_data = is_tone && (head_val[9:4] != shadow[head_reg][9:4]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    end else if (pop) begin
      shadow[head_reg] <= head_val & mask;
    end
  end
`else
  assign drop      = 1'b0;
  assign need_data = is_tone;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      wr_n   <= 1'b1;
      dout   <= 8'h00;
      pend   <= 1'b0;
      data_q <= '0;
      gcnt   <= '0;
    end else begin
      st     <= st_n;
      wr_n   <= wr_n_n;
      dout   <= dout_n;
      pend   <= pend_n;
      data_q <= data_n;
      gcnt   <= gcnt_n;
    end
  end

  always_comb begin
    logic fin, launch;
    st_n   = st;
    wr_n_n = wr_n;
    dout_n = dout;
    pend_n = pend;
    data_n = data_q;
    gcnt_n = gcnt;
    pop    = 1'b0;
    fin    = 1'b0;
    launch = 1'b0;
    if (cen) begin
      case (st)
        S_IDLE: launch = nonempty;
        S_LATCH, S_DATA: begin
          if (GAP_W == 4'd0) begin
            fin = 1'b1;
          end else begin
            st_n   = S_GAP;
            wr_n_n = 1'b1;
            gcnt_n = GAP_W - 4'd1;
          end
        end
        S_GAP: begin
          if (gcnt == 4'd0) fin = 1'b1;
          else              gcnt_n = gcnt - 4'd1;
        end
        default: st_n = S_IDLE;
      endcase
      // Gap end goes straight to the next latch so back-to-back requests keep (GAP+1) spacing
      if (fin) begin
        if (pend) begin
          st_n   = S_DATA;
          wr_n_n = 1'b0;
          dout_n = {2'b00, data_q};
          pend_n = 1'b0;
        end else if (nonempty) begin
          launch = 1'b1;
        end else begin
          st_n   = S_IDLE;
          wr_n_n = 1'b1;
        end
      end
      if (launch) begin
        pop    = 1'b1;
        pend_n = need_data && !drop;
        data_n = head_val[9:4];
        if (drop) begin
          st_n   = S_IDLE;
          wr_n_n = 1'b1;
        end else begin
          st_n   = S_LATCH;
          wr_n_n = 1'b0;
          dout_n = {1'b1, head_reg, low4};
        end
      end
    end
  end

endmodule

// File: tb/tb_jt89_wrseq.sv
// Directed bench for jt89_wrseq; byte stream checked against a queue of expected PSG bytes.
module tb_jt89_wrseq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_reg;
  logic [9:0] req_val;
  logic       wr_n;
  logic [7:0] dout;
  logic       busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cdiv  = 0;
  bit   cen_on = 1'b1;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  jt89_wrseq #(.DEPTH(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val),
    .wr_n(wr_n), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    cen = 1'b0;
    forever begin
      @(negedge clk);
      cdiv++;
      cen = cen_on && (cdiv % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Every cen window with wr_n low is one byte delivered to the PSG.
  always @(posedge clk) begin
    if (cen && rst_n) begin
      #1;
      if (rst_n && !wr_n) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL sb_unexpected: got byte %h expected none", dout);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_byte", {8'h00, dout}, {8'h00, mon_exp});
        end
      end
    end
  end

  task automatic cen_step();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (cen) break;
    end
    #1;
  endtask

  task automatic wait_byte(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cen_step();
      if (!wr_n) got = 1'b1;
    end
    chk(tag, {15'd0, got}, 16'd1);
  endtask

  task automatic push_req(input logic [2:0] r, input logic [9:0] v);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    chk("push_ready", {15'd0, ok}, 16'd1);
    req_valid = 1'b1;
    req_reg   = r;
    req_val   = v;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0) break;
    end
    chk(tag, {15'd0, busy}, 16'd0);
    chk({tag, "_sb"}, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0;
    req_reg = '0;
    req_val = '0;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_wr_n", {15'd0, wr_n}, 16'd1);
    chk("rst_dout", {8'h00, dout}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ready", {15'd0, req_ready}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // tone0 = 3FE: latch, one idle window, data, then idle
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h3F);
    push_req(3'd0, 10'h3FE);
    wait_byte("t1_wait");
    chk("t1_latch", {8'h00, dout}, 16'h008E);
    cen_step();
    chk("t1_gap_wr_n", {15'd0, wr_n}, 16'd1);
    chk("t1_gap_dout", {8'h00, dout}, 16'h008E);
    cen_step();
    chk("t1_data_wr_n", {15'd0, wr_n}, 16'd0);
    chk("t1_data", {8'h00, dout}, 16'h003F);
    cen_step();
    chk("t1_gap2_wr_n", {15'd0, wr_n}, 16'd1);
    cen_step();
    chk("t1_idle_busy", {15'd0, busy}, 16'd0);
    chk("t1_idle_wr_n", {15'd0, wr_n}, 16'd1);

    // vol2 = A: single byte
    exp_q.push_back(8'hDA);
    push_req(3'd5, 10'h00A);
    wait_byte("t2_wait");
    chk("t2_byte", {8'h00, dout}, 16'h00DA);
    cen_step();
    chk("t2_one_window", {15'd0, wr_n}, 16'd1);
    wait_idle("t2_idle");

    // noise: upper value bits ignored
    exp_q.push_back(8'hE5);
    push_req(3'd6, 10'h3FD);
    wait_byte("t3_wait");
    chk("t3_byte", {8'h00, dout}, 16'h00E5);
    cen_step();
    chk("t3_one_window", {15'd0, wr_n}, 16'd1);
    wait_idle("t3_idle");

    // cen stalled: FIFO fills, extra request refused, order preserved
    cen_on = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h91);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hF3);
    exp_q.push_back(8'hD4);
    push_req(3'd1, 10'h001);
    push_req(3'd3, 10'h002);
    push_req(3'd7, 10'h003);
    chk("t4_ready_3", {15'd0, req_ready}, 16'd1);
    push_req(3'd5, 10'h004);
    chk("t4_full", {15'd0, req_ready}, 16'd0);
    chk("t4_busy", {15'd0, busy}, 16'd1);
    req_valid = 1'b1;
    req_reg   = 3'd1;
    req_val   = 10'h005;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    chk("t4_still_full", {15'd0, req_ready}, 16'd0);
    chk("t4_frozen", {15'd0, wr_n}, 16'd1);
    cen_on = 1'b1;
    wait_idle("t4_drain");

    // reset mid data byte of tone1
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    push_req(3'd2, 10'h3C5);
    wait_byte("t5_wait");
    chk("t5_latch", {8'h00, dout}, 16'h00A5);
    cen_step();
    cen_step();
    chk("t5_in_data", {7'd0, wr_n, dout}, 16'h003C);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_n", {15'd0, wr_n}, 16'd1);
    chk("t5_rst_dout", {8'h00, dout}, 16'h0000);
    chk("t5_rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cen_step();
    chk("t5_after_wr_n", {15'd0, wr_n}, 16'd1);
    chk("t5_after_busy", {15'd0, busy}, 16'd0);
    chk("t5_sb", 16'(exp_q.size()), 16'd0);

    // repeated tone1 writes
`ifdef JT89_WRSEQ_SHADOW_EN
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hA4);
`else
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'h12);
`endif
    push_req(3'd2, 10'h123);
    push_req(3'd2, 10'h123);
    push_req(3'd2, 10'h124);
    wait_idle("t6_idle");
    chk("t6_wr_n", {15'd0, wr_n}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
